// File: rtl/blk_tx_pkg.sv
// Shared constants and FSM encoding for the framed UART transmitter.
package blk_tx_pkg;

   localparam int unsigned ADDR_W           = 10;
   localparam int unsigned LEN_W            = 11;
   localparam int unsigned DEPTH_MAX        = 1024;
   localparam int unsigned CLKS_PER_BIT_DEF = 87;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StLoad  = 3'd2,
      StSend  = 3'd3,
      StFin   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/blk_tx_ser.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit.
// done is high during the last cycle of the stop bit.
module blk_tx_ser #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       active,
   output logic       done
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      bit_q, bit_d;
   logic [8:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            active_q, active_d;
   logic            bit_end;

   // Bit timing and shift-out; bit_q 0 is the start bit, 9 the stop bit.
   always_comb begin
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      tx_d     = tx_q;
      active_d = active_q;
      bit_end  = active_q && (cnt_q == CntMax);
      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         bit_d    = '0;
         // Stop bit rides in the top position so it shifts out after data bit 7.
         shreg_d  = {1'b1, data};
         tx_d     = 1'b0;
      end else if (active_q) begin
         if (bit_end) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
               active_d = 1'b0;
               tx_d     = 1'b1;
            end else begin
               bit_d   = bit_q + 4'd1;
               tx_d    = shreg_q[0];
               shreg_d = {1'b1, shreg_q[8:1]};
            end
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Serializer state; the line is driven straight from tx_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '1;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         active_q <= active_d;
      end
   end

   assign tx     = tx_q;
   assign active = active_q;
   assign done   = bit_end && (bit_q == 4'd9);

endmodule

// File: rtl/blk_tx_frame.sv
// Frame transmitter: sends i_len bytes from an internal buffer over 8N1 UART,
// starting at i_base_addr with the address wrapping modulo the buffer size.
module blk_tx_frame
   import blk_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DEPTH        = DEPTH_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [LEN_W-1:0]  i_len,
   output logic              o_uart_tx,
   output logic              o_busy,
   output logic              o_done,
   output logic [LEN_W-1:0]  o_byte_cnt
);

   tx_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [1:0]        rst_sync_q;
   logic              rst_n_sync;
   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        rd_data_q;
   logic              ser_start, ser_tx, ser_active, ser_done;

   // Reset asserts asynchronously and releases two clocks after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_n_sync = rst_sync_q[1];

   // Frame buffer: write any time, registered read returns pre-write data.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
      rd_data_q <= mem_q[addr_q];
   end

   // Frame sequencing: FETCH/LOAD add the two idle-high cycles between bytes.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      ser_start  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_start && (i_len != '0) && (i_len <= LEN_W'(DEPTH_MAX))) begin
               addr_d     = i_base_addr;
               len_d      = i_len;
               byte_cnt_d = '0;
               state_d    = StFetch;
            end
         end
         StFetch: state_d = StLoad;
         StLoad: begin
            ser_start = 1'b1;
            state_d   = StSend;
         end
         StSend: begin
            if (ser_done) begin
               byte_cnt_d = byte_cnt_q + LEN_W'(1);
               if (byte_cnt_d == len_q) begin
                  state_d = StFin;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = StFetch;
               end
            end else if (!ser_active) begin
               // Serializer lost its byte without finishing; do not hang busy.
               state_d = StIdle;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   blk_tx_ser #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk   (clk),
      .rst_n (rst_n_sync),
      .start (ser_start),
      .data  (rd_data_q),
      .tx    (ser_tx),
      .active(ser_active),
      .done  (ser_done)
   );

   assign o_uart_tx  = ser_tx;
   assign o_busy     = (state_q == StFetch) || (state_q == StLoad) || (state_q == StSend);
   assign o_done     = (state_q == StFin);
   assign o_byte_cnt = byte_cnt_q;

endmodule

// File: doc/blk_tx_frame.md
BLK_TX_FRAME -- requirements
Module: blk_tx_frame

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, giving clk cycles per UART bit.
REQ-002 The block SHALL have parameter DEPTH, default 1024, giving the frame buffer depth in bytes.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  the single clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 i_wr_en  in  1  when high, writes i_wr_data to buffer[i_wr_addr].
REQ-007 i_wr_addr  in  10  buffer write address.
REQ-008 i_wr_data  in  8  buffer write data.
REQ-009 i_start  in  1  frame start request, sampled only in IDLE.
REQ-010 i_base_addr  in  10  buffer address of the first frame byte.
REQ-011 i_len  in  11  frame length in bytes; legal range 1..1024.
REQ-012 o_uart_tx  out  1  serial line, 8N1, LSB first, idle high.
REQ-013 o_busy  out  1  high while a frame is in progress.
REQ-014 o_done  out  1  one-cycle pulse when the last stop bit completes.
REQ-015 o_byte_cnt  out  11  number of bytes fully sent in the current frame.

Function
REQ-016 The buffer SHALL be a DEPTH x 8 simple dual-port RAM with a 1-cycle synchronous read; a same-address write and read in one cycle SHALL return the old data.
REQ-017 The FSM SHALL have the states IDLE, FETCH, LOAD, SEND and FIN.
REQ-018 In IDLE, i_start=1 with i_len in 1..1024 SHALL latch i_base_addr and i_len, clear o_byte_cnt and enter FETCH; otherwise the FSM SHALL stay in IDLE.
REQ-019 FETCH SHALL present the read address for one cycle; LOAD SHALL capture the read data and pulse the serializer start for one cycle; the FSM SHALL then enter SEND.
REQ-020 o_uart_tx SHALL fall exactly 3 cycles after the cycle in which i_start was sampled.
REQ-021 Each byte SHALL occupy exactly 10*CLKS_PER_BIT cycles: a low start bit, data bits 0..7, then a high stop bit.
REQ-022 At the end of each stop bit, o_byte_cnt SHALL increment; if o_byte_cnt then equals the latched length, the FSM SHALL enter FIN, otherwise the address SHALL increment and the FSM SHALL enter FETCH.
REQ-023 The line SHALL idle high for exactly 2 cycles between the end of one stop bit and the next start bit.
REQ-024 The read address SHALL wrap modulo 1024 (address 1023 + 1 = 0).
REQ-025 FIN SHALL last one cycle, assert o_done and return to IDLE.
REQ-026 o_busy SHALL be high in FETCH, LOAD and SEND, and low in IDLE and FIN.
REQ-027 i_start while busy, i_len=0 and i_len>1024 SHALL be ignored, with no busy, no done and no line activity.
REQ-028 Writes SHALL be accepted in every state; a byte written before its FETCH cycle SHALL be transmitted with the new value.
REQ-029 The serializer SHALL drive o_uart_tx from a register, so the output has no combinational glitches.

Reset
REQ-030 On rst_n low, the state SHALL become IDLE, o_uart_tx=1, o_busy=0, o_done=0, o_byte_cnt=0, and the serializer counters SHALL be cleared.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately and produce no o_done.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 rst_n SHALL be released synchronously to clk by a two-flop synchronizer inside the block.

Structure
REQ-034 Shared package blk_tx_pkg SHALL hold ADDR_W=10, LEN_W=11, DEPTH_MAX=1024, the default CLKS_PER_BIT and the FSM state encoding.
REQ-035 The block SHALL contain one sub-module, blk_tx_ser: an 8N1 serializer with ports clk, rst_n, start, data[7:0], tx, active and done.
REQ-036 The buffer SHALL be inferred RAM, not a vendor core.

Verification (CLKS_PER_BIT=4)
REQ-037 Write 0x55 at address 0, then start with base=0, len=1 -> tx falls at T+3 and shows 4 low, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then 4 high; o_done pulses once; o_byte_cnt=1.
REQ-038 Write 0xA1,0xB2,0xC3,0xD4 at addresses 1022,1023,0,1, then start with base=1022, len=4 -> bytes are sent in that order; each inter-byte gap is exactly 2 idle cycles.
REQ-039 i_start with len=0, with len=1025, and again while busy -> no line activity and no extra o_done.
REQ-040 Assert rst_n low mid-data-bit of byte 2 of 3 -> tx=1, busy=0 and no done immediately; a new start afterwards sends a correct frame.
REQ-041 During byte 0 of a 3-byte frame, overwrite byte 2 with 0x3C -> 0x3C is transmitted.
REQ-042 Start with len=1024 -> exactly 1024 bytes are sent, o_byte_cnt=1024 at o_done, and busy falls in the FIN cycle.
